// File: rtl/qsys_design_nios2_qsys_0_oci_dct_packer.sv
// OCI trace fragment packer: packs 3-bit fragments into 10-slot words with a RUN/DRAIN/ENDED run controller.
// Optional: define OCI_DCT_OVF_COUNT_EN to add the saturating ovf_count output.
module qsys_design_nios2_qsys_0_oci_dct_packer #(
  parameter int END_DRAIN_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frag_valid,
  input  logic [2:0]  frag,
  input  logic        flush,
  input  logic        trace_end,
  input  logic        word_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        word_valid,
  output logic [29:0] word_data,
  output logic [3:0]  word_cnt,
  output logic        ovf,
  output logic        test_ending,
`ifdef OCI_DCT_OVF_COUNT_EN
  output logic [7:0]  ovf_count,
`endif
  output logic        test_has_ended
);

  localparam int NUM_SLOTS = 10;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ENDED} state_t;

  state_t                      state_q, state_d;
  logic [NUM_SLOTS-1:0][2:0]   slots_q, slots_d;
  logic [7:0]                  drain_timer;
  logic                        flush_pend;

  logic live, frag_acc, new_flush, flush_req, slot_free, full, empty, xfer, drop, drain_to;

  always_comb begin
    live      = (state_q != ST_ENDED);
    frag_acc  = frag_valid && live;
    // trace_end carries an implicit flush so the tail of the run is emitted
    new_flush = live && (flush || (trace_end && state_q == ST_RUN));
    flush_req = flush_pend || new_flush;
    slot_free = !word_valid || word_ready;
    full      = (dct_count == 4'(NUM_SLOTS));
    empty     = (dct_count == 4'd0);
    xfer      = slot_free && (full || (flush_req && !empty));
    drop      = frag_acc && full && !xfer;
    drain_to  = (drain_timer == 8'(END_DRAIN_MAX - 1));
  end

  // A transfer empties the buffer, so a same-edge fragment lands in slot 0
  always_comb begin
    slots_d = slots_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (xfer) slots_d[i] = 3'b000;
      if (frag_acc && (xfer ? (i == 0) : (dct_count == 4'(i)))) slots_d[i] = frag;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (trace_end) state_d = ST_DRAIN;
      ST_DRAIN: if ((empty && !word_valid) || drain_to) state_d = ST_ENDED;
      default:  state_d = ST_ENDED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_timer <= 8'd0;
    end else begin
      state_q     <= state_d;
      drain_timer <= (state_q == ST_DRAIN) ? drain_timer + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots_q    <= '0;
      dct_count  <= 4'd0;
      flush_pend <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      slots_q    <= slots_d;
      flush_pend <= !xfer && flush_req && !empty;
      ovf        <= ovf || drop;
      if (xfer)                  dct_count <= frag_acc ? 4'd1 : 4'd0;
      else if (frag_acc && !full) dct_count <= dct_count + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_valid <= 1'b0;
      word_data  <= 30'd0;
      word_cnt   <= 4'd0;
    end else if (xfer) begin
      word_valid <= 1'b1;
      word_data  <= slots_q;
      word_cnt   <= dct_count;
    end else if (word_ready) begin
      word_valid <= 1'b0;
    end
  end

`ifdef OCI_DCT_OVF_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         ovf_count <= 8'd0;
    else if (drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
  end
`endif

  assign dct_buffer     = slots_q;
  assign test_ending    = (state_q == ST_DRAIN);
  assign test_has_ended = (state_q == ST_ENDED);

endmodule

// File: tb/tb_qsys_design_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench for the OCI DCT packer against a queue-based reference model.
module tb_qsys_design_nios2_qsys_0_oci_dct_packer;
  localparam int MAX = 15;

  logic clk = 1'b0;
  logic reset, frag_valid, flush, trace_end, word_ready;
  logic [2:0]  frag;
  logic [29:0] dct_buffer, word_data;
  logic [3:0]  dct_count, word_cnt;
  logic        word_valid, ovf, test_ending, test_has_ended;
`ifdef OCI_DCT_OVF_COUNT_EN
  logic [7:0]  ovf_count;
`endif

  qsys_design_nios2_qsys_0_oci_dct_packer #(.END_DRAIN_MAX(MAX)) dut (
    .clk(clk), .reset(reset), .frag_valid(frag_valid), .frag(frag), .flush(flush),
    .trace_end(trace_end), .word_ready(word_ready), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .word_valid(word_valid), .word_data(word_data),
    .word_cnt(word_cnt), .ovf(ovf), .test_ending(test_ending),
`ifdef OCI_DCT_OVF_COUNT_EN
    .ovf_count(ovf_count),
`endif
    .test_has_ended(test_has_ended));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // Reference model: buffered fragments as a queue, run phase as 0=run 1=drain 2=ended
  logic [2:0]  mq[$];
  bit          m_wv, m_ovf, m_pend;
  logic [29:0] m_wd;
  logic [3:0]  m_wc;
  int          m_ovfc, m_st, m_t;

  function automatic logic [29:0] pack_q();
    logic [29:0] r = '0;
    for (int i = 0; i < mq.size(); i++) r[3*i +: 3] = mq[i];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete(); m_wv = 0; m_ovf = 0; m_pend = 0; m_wd = '0; m_wc = '0;
    m_ovfc = 0; m_st = 0; m_t = 0;
  endtask

  task automatic tick();
    int n; bit acc, nf, pend, go, leave;
    @(posedge clk);
    n     = mq.size();
    acc   = frag_valid && m_st != 2;
    nf    = m_st != 2 && (flush || (trace_end && m_st == 0));
    pend  = m_pend || nf;
    go    = (!m_wv || word_ready) && (n == 10 || (pend && n > 0));
    leave = m_st == 1 && ((n == 0 && !m_wv) || m_t + 1 >= MAX);
    if (go) begin m_wd = pack_q(); m_wc = 4'(n); m_wv = 1; mq.delete(); end
    else if (word_ready) m_wv = 0;
    if (acc) begin
      if (mq.size() < 10) mq.push_back(frag);
      else begin m_ovf = 1; if (m_ovfc < 255) m_ovfc++; end
    end
    m_pend = !go && pend && n > 0;
    if (m_st == 0 && trace_end) begin m_st = 1; m_t = 0; end
    else if (m_st == 1) begin if (leave) m_st = 2; else m_t++; end
    #1;
  endtask

  task automatic idle();
    frag_valid = 0; frag = 0; flush = 0; trace_end = 0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; model_reset();
    @(posedge clk); #1; reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if ({dct_buffer, dct_count, word_valid, word_data, word_cnt, ovf, test_ending, test_has_ended} !== '0)
      $display("FAIL reset_outputs got buf=%h cnt=%0d wv=%b wd=%h wc=%0d ovf=%b te=%b th=%b want all 0",
               dct_buffer, dct_count, word_valid, word_data, word_cnt, ovf, test_ending, test_has_ended);
    else n_pass++;
  endtask

  task automatic test_full_word();
    logic [2:0] vals [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
    do_reset(); word_ready = 1;
    for (int i = 0; i < 10; i++) begin frag_valid = 1; frag = vals[i]; tick(); end
    idle();
    n_chk++; if (dct_count !== 4'd10) $display("FAIL full_fill_cnt got %0d want 10", dct_count); else n_pass++;
    tick();
    n_chk++; if (word_valid !== 1'b1) $display("FAIL full_wv got %b want 1", word_valid); else n_pass++;
    n_chk++; if (word_data !== 30'o1076543210) $display("FAIL full_data got %h want %h", word_data, 30'o1076543210); else n_pass++;
    n_chk++; if (word_cnt !== 4'd10) $display("FAIL full_wcnt got %0d want 10", word_cnt); else n_pass++;
    n_chk++; if (dct_count !== 4'd0) $display("FAIL full_empty got %0d want 0", dct_count); else n_pass++;
  endtask

  task automatic test_partial_flush();
    logic [2:0] vals [3] = '{5, 2, 7};
    do_reset(); word_ready = 1;
    for (int i = 0; i < 3; i++) begin frag_valid = 1; frag = vals[i]; tick(); end
    idle(); tick();
    n_chk++; if (word_valid !== 1'b0) $display("FAIL pflush_no_early got %b want 0", word_valid); else n_pass++;
    flush = 1; tick(); flush = 0;
    n_chk++; if (word_data !== 30'h1D5) $display("FAIL pflush_data got %h want 1d5", word_data); else n_pass++;
    n_chk++; if (word_cnt !== 4'd3 || word_valid !== 1'b1) $display("FAIL pflush_wcnt got %0d/%b want 3/1", word_cnt, word_valid); else n_pass++;
    tick(); flush = 1; tick(); flush = 0;
    n_chk++; if (word_valid !== 1'b0) $display("FAIL empty_flush_wv got %b want 0", word_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [2:0] v [21];
    logic [29:0] exp_w = '0, exp_b = '0;
    do_reset(); word_ready = 0;
    for (int i = 0; i < 21; i++) begin v[i] = 3'($urandom); frag_valid = 1; frag = v[i]; tick(); end
    idle();
    for (int i = 0; i < 10; i++) begin exp_w[3*i +: 3] = v[i]; exp_b[3*i +: 3] = v[10+i]; end
    n_chk++; if (word_data !== exp_w) $display("FAIL ovf_word got %h want %h", word_data, exp_w); else n_pass++;
    n_chk++; if (dct_buffer !== exp_b) $display("FAIL ovf_buf got %h want %h", dct_buffer, exp_b); else n_pass++;
    n_chk++; if (dct_count !== 4'd10 || word_cnt !== 4'd10) $display("FAIL ovf_cnts got %0d/%0d want 10/10", dct_count, word_cnt); else n_pass++;
    n_chk++; if (ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", ovf); else n_pass++;
`ifdef OCI_DCT_OVF_COUNT_EN
    n_chk++; if (ovf_count !== 8'd1) $display("FAIL ovf_count got %0d want 1", ovf_count); else n_pass++;
`endif
  endtask

  task automatic test_drain();
    logic [29:0] exp_w = '0;
    do_reset(); word_ready = 1;
    for (int i = 0; i < 4; i++) begin frag_valid = 1; frag = 3'($urandom); exp_w[3*i +: 3] = frag; tick(); end
    idle(); trace_end = 1; tick(); trace_end = 0;
    n_chk++; if (test_ending !== 1'b1) $display("FAIL drain_ending got %b want 1", test_ending); else n_pass++;
    n_chk++; if (word_valid !== 1'b1 || word_cnt !== 4'd4 || word_data !== exp_w)
      $display("FAIL drain_word got %b/%0d/%h want 1/4/%h", word_valid, word_cnt, word_data, exp_w); else n_pass++;
    tick(); tick();
    n_chk++; if (test_has_ended !== 1'b1 || test_ending !== 1'b0)
      $display("FAIL drain_ended got th=%b te=%b want 1/0", test_has_ended, test_ending); else n_pass++;
  endtask

  task automatic test_drain_timeout();
    do_reset(); word_ready = 0;
    frag_valid = 1; frag = 3; tick(); frag = 6; tick(); idle();
    flush = 1; tick(); flush = 0;
    trace_end = 1; tick(); trace_end = 0;
    for (int k = 1; k <= 14; k++) begin
      n_chk++; if (test_ending !== 1'b1) $display("FAIL timeout_ending cycle %0d got %b want 1", k, test_ending); else n_pass++;
      tick();
    end
    n_chk++; if (test_ending !== 1'b1) $display("FAIL timeout_ending cycle 15 got %b want 1", test_ending); else n_pass++;
    tick();
    n_chk++; if (test_has_ended !== 1'b1 || test_ending !== 1'b0 || word_valid !== 1'b1)
      $display("FAIL timeout_ended got th=%b te=%b wv=%b want 1/0/1", test_has_ended, test_ending, word_valid); else n_pass++;
    frag_valid = 1; frag = 5; trace_end = 1; tick(); idle();
    n_chk++; if (dct_count !== 4'd0 || test_has_ended !== 1'b1) $display("FAIL ended_ignores got cnt=%0d th=%b want 0/1", dct_count, test_has_ended); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset(); word_ready = 0;
    for (int i = 0; i < 6; i++) begin frag_valid = 1; frag = 3'($urandom_range(1, 7)); tick(); end
    idle();
    n_chk++; if (dct_count !== 4'd6) $display("FAIL areset_pre got %0d want 6", dct_count); else n_pass++;
    #2; reset = 1; #1;
    n_chk++; if ({dct_buffer, dct_count, word_valid, word_data, word_cnt, ovf, test_ending, test_has_ended} !== '0)
      $display("FAIL areset_async got buf=%h cnt=%0d wv=%b want all 0", dct_buffer, dct_count, word_valid);
    else n_pass++;
    model_reset(); @(posedge clk); #1; reset = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if (c % 400 == 399) do_reset();
      frag_valid = ($urandom_range(0, 3) != 0);
      frag       = 3'($urandom);
      flush      = ($urandom_range(0, 15) == 0);
      trace_end  = ($urandom_range(0, 150) == 0);
      word_ready = ($urandom_range(0, 9) < 6);
      tick();
      n_chk++;
      if (dct_buffer !== pack_q() || dct_count !== 4'(mq.size()) || word_valid !== m_wv ||
          word_data !== m_wd || word_cnt !== m_wc || ovf !== m_ovf ||
          test_ending !== (m_st == 1) || test_has_ended !== (m_st == 2))
        $display("FAIL rand_cycle %0d got buf=%h cnt=%0d wv=%b wd=%h wc=%0d ovf=%b te=%b th=%b want buf=%h cnt=%0d wv=%b wd=%h wc=%0d ovf=%b st=%0d",
                 c, dct_buffer, dct_count, word_valid, word_data, word_cnt, ovf, test_ending, test_has_ended,
                 pack_q(), mq.size(), m_wv, m_wd, m_wc, m_ovf, m_st);
      else n_pass++;
`ifdef OCI_DCT_OVF_COUNT_EN
      n_chk++; if (ovf_count !== 8'(m_ovfc)) $display("FAIL rand_ovf_count %0d got %0d want %0d", c, ovf_count, m_ovfc); else n_pass++;
`endif
    end
    idle();
  endtask

  initial begin
    reset = 1; word_ready = 0; idle();
    #1;
    test_reset();
    test_full_word();
    test_partial_flush();
    test_overflow();
    test_drain();
    test_drain_timeout();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
